// File: rtl/legup_mult_stallable.sv
// Pipelined multiplier with valid-bit stages and bubble collapsing; the product appears `pipeline` cycles after acceptance.
// Backpressure: in_ready ripples combinationally back from out_ready, so a full pipe accepts and emits in the same cycle.
module legup_mult_stallable #(
    parameter int widtha         = 32,
    parameter int widthb         = 32,
    parameter int widthp         = 64,
    parameter int pipeline       = 3,
    parameter     representation = "UNSIGNED"
) (
    input  logic              clock,
    input  logic              aclr,
    input  logic              clken,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [widtha-1:0] dataa,
    input  logic [widthb-1:0] datab,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [widthp-1:0] result
);

    localparam int FW        = widtha + widthb;
    localparam int MW        = (widthp > FW) ? widthp : FW;
    localparam bit IS_SIGNED = (representation == "SIGNED");

    // Operands are extended to the wider of the full product and the result width,
    // so the low bits of one plain multiply already carry the required sign/zero extension.
    logic [MW-1:0]     a_ext;
    logic [MW-1:0]     b_ext;
    logic [MW-1:0]     prod_full;
    logic [widthp-1:0] prod_d;

    assign a_ext     = IS_SIGNED ? {{(MW-widtha){dataa[widtha-1]}}, dataa}
                                 : {{(MW-widtha){1'b0}}, dataa};
    assign b_ext     = IS_SIGNED ? {{(MW-widthb){datab[widthb-1]}}, datab}
                                 : {{(MW-widthb){1'b0}}, datab};
    assign prod_full = a_ext * b_ext;
    assign prod_d    = prod_full[widthp-1:0];

    logic [pipeline-1:0] stage_vld_q;
    logic [widthp-1:0]   stage_dat_q [pipeline];
    logic [pipeline-1:0] stage_ld;
    logic                ld_chain;

    // A stage may load when it is empty or when everything downstream of it can move.
    always_comb begin
        stage_ld = '0;
        ld_chain = out_ready;
        for (int k = pipeline - 1; k >= 0; k--) begin
            stage_ld[k] = !stage_vld_q[k] || ld_chain;
            ld_chain    = stage_ld[k];
        end
    end

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            stage_vld_q <= '0;
            for (int k = 0; k < pipeline; k++) begin
                stage_dat_q[k] <= '0;
            end
        end else if (clken) begin
            if (stage_ld[0]) begin
                stage_vld_q[0] <= in_valid;
                if (in_valid) begin
                    stage_dat_q[0] <= prod_d;
                end
            end
            for (int k = 1; k < pipeline; k++) begin
                if (stage_ld[k]) begin
                    stage_vld_q[k] <= stage_vld_q[k-1];
                    if (stage_vld_q[k-1]) begin
                        stage_dat_q[k] <= stage_dat_q[k-1];
                    end
                end
            end
        end
    end

    assign in_ready  = clken && stage_ld[0];
    assign out_valid = stage_vld_q[pipeline-1];
    assign result    = stage_dat_q[pipeline-1];

endmodule

// File: tb/tb_legup_mult_stallable.sv
// Scoreboard bench for legup_mult_stallable: default 32x32 instance plus small signed/unsigned variants.
module tb_legup_mult_stallable;

    logic        clock     = 1'b0;
    logic        aclr      = 1'b1;
    logic        clken     = 1'b1;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] dataa     = '0;
    logic [31:0] datab     = '0;
    logic        in_ready;
    logic        out_valid;
    logic [63:0] result;

    logic        sm_vld = 1'b0;
    logic [7:0]  sm_a   = '0;
    logic [7:0]  sm_b   = '0;
    logic        s8_rdy, s8_vld, u8_rdy, u8_vld, sx_rdy, sx_vld;
    logic [15:0] s8_res, u8_res;
    logic [23:0] sx_res;

    int          n_chk   = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          acc_cyc = 0;
    logic [63:0] sb[$];
    logic        prev_stall = 1'b0;
    logic [63:0] prev_res   = '0;
    bit          rnd_on     = 1'b0;

    legup_mult_stallable u_dut (
        .clock(clock), .aclr(aclr), .clken(clken),
        .in_valid(in_valid), .in_ready(in_ready),
        .dataa(dataa), .datab(datab),
        .out_valid(out_valid), .out_ready(out_ready), .result(result)
    );

    legup_mult_stallable #(.widtha(8), .widthb(8), .widthp(16), .pipeline(3), .representation("SIGNED")) u_s8 (
        .clock(clock), .aclr(aclr), .clken(clken),
        .in_valid(sm_vld), .in_ready(s8_rdy), .dataa(sm_a), .datab(sm_b),
        .out_valid(s8_vld), .out_ready(out_ready), .result(s8_res)
    );

    legup_mult_stallable #(.widtha(8), .widthb(8), .widthp(16), .pipeline(3), .representation("UNSIGNED")) u_u8 (
        .clock(clock), .aclr(aclr), .clken(clken),
        .in_valid(sm_vld), .in_ready(u8_rdy), .dataa(sm_a), .datab(sm_b),
        .out_valid(u8_vld), .out_ready(out_ready), .result(u8_res)
    );

    legup_mult_stallable #(.widtha(8), .widthb(8), .widthp(24), .pipeline(1), .representation("SIGNED")) u_sx (
        .clock(clock), .aclr(aclr), .clken(clken),
        .in_valid(sm_vld), .in_ready(sx_rdy), .dataa(sm_a), .datab(sm_b),
        .out_valid(sx_vld), .out_ready(out_ready), .result(sx_res)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: push the reference product on every input transfer, pop on every output transfer.
    always @(negedge clock) begin
        if (aclr) begin
            sb.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_vld", out_valid, 1);
                chk("hold_res", result, prev_res);
            end
            if (clken && out_valid && out_ready) begin
                chk("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) chk("result", result, sb.pop_front());
            end
            if (clken && in_valid && in_ready)
                sb.push_back({32'b0, dataa} * {32'b0, datab});
            prev_stall = out_valid && !out_ready;
            prev_res   = result;
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b);
        int w = 0;
        in_valid = 1'b1;
        dataa    = a;
        datab    = b;
        @(negedge clock);
        while (!in_ready && w < 100) begin
            w++;
            @(negedge clock);
        end
        chk("send_rdy", in_ready, 1);
        acc_cyc = cyc;
        @(posedge clock);
        #1;
    endtask

    task automatic wait_out(output int lat);
        int w = 0;
        @(negedge clock);
        while (!out_valid && w < 100) begin
            w++;
            @(negedge clock);
        end
        lat = cyc - acc_cyc;
    endtask

    task automatic drain();
        int w = 0;
        while (sb.size() != 0 && w < 50) begin
            @(negedge clock);
            w++;
        end
        chk("drain", sb.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        repeat (2) @(posedge clock);
        #1;
        @(negedge clock);
        chk("rst_vld", out_valid, 0);
        chk("rst_res", result, 0);
        chk("rst_rdy", in_ready, 1);
        chk("rst_small_vld", {s8_vld, u8_vld, sx_vld}, 0);
        chk("rst_small_rdy", {s8_rdy, u8_rdy, sx_rdy}, 3'b111);

        // First edge after reset release accepts 7*6 and the small-width pairs.
        @(posedge clock);
        #1;
        aclr      = 1'b0;
        out_ready = 1'b1;
        sm_vld    = 1'b1;
        sm_a      = 8'hFF;
        sm_b      = 8'h02;
        send(32'd7, 32'd6);
        in_valid = 1'b0;
        sm_vld   = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clock);
            chk("lat3_vld", out_valid, (i == 3));
            if (i == 1) begin
                chk("sx_vld", sx_vld, 1);
                chk("sx_res", sx_res, 24'hFFFFFE);
            end
            if (i == 3) begin
                chk("res42", result, 64'd42);
                chk("small_vld", {s8_vld, u8_vld}, 2'b11);
                chk("s8_res", s8_res, 16'hFFFE);
                chk("u8_res", u8_res, 16'h01FE);
            end
        end

        // Fill with out_ready low, then release and refill in the same cycle.
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        send(32'd1, 32'd1);
        send(32'd2, 32'd2);
        send(32'd3, 32'd3);
        dataa = 32'd4;
        datab = 32'd4;
        @(negedge clock);
        chk("full_rdy", in_ready, 0);
        chk("full_res", result, 64'd1);
        repeat (2) @(negedge clock);
        chk("full_rdy2", in_ready, 0);
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        @(negedge clock);
        chk("refill_rdy", in_ready, 1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        drain();

        // Random back-to-back stream with random consumer stalls.
        @(posedge clock);
        #1;
        rnd_on = 1'b1;
        fork
            begin
                while (rnd_on) begin
                    @(posedge clock);
                    #1;
                    if (rnd_on) out_ready = 1'($urandom_range(0, 1));
                end
            end
        join_none
        for (int i = 0; i < 100; i++) send($urandom, $urandom);
        in_valid = 1'b0;
        rnd_on   = 1'b0;
        @(posedge clock);
        #2;
        out_ready = 1'b1;
        drain();

        // Reset with two products in flight.
        @(posedge clock);
        #1;
        send(32'd5, 32'd5);
        send(32'd6, 32'd6);
        in_valid = 1'b0;
        @(posedge clock);
        #1;
        chk("pre_rst_vld", out_valid, 1);
        aclr = 1'b1;
        #1;
        chk("mid_rst_vld", out_valid, 0);
        chk("mid_rst_res", result, 0);
        @(posedge clock);
        #1;
        aclr = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            chk("no_stale", out_valid, 0);
        end

        // Freeze one product in flight for five cycles.
        @(posedge clock);
        #1;
        send(32'd3, 32'd4);
        in_valid = 1'b0;
        clken    = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("frz_rdy", in_ready, 0);
            chk("frz_vld", out_valid, 0);
            @(posedge clock);
            #1;
        end
        clken = 1'b1;
        wait_out(lat);
        chk("stall_lat", lat, 8);
        chk("stall_res", result, 64'd12);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
